systolic_feeder: RTL

Front-end transmitter for the systolic PE array: drives the `weight_in`/`load_weight` and `input_in`/`start` ports on the array's edge. It accepts weight rows and input vectors over valid/ready handshakes, and loads weights row by row. It then streams input vectors into the array rows with the diagonal skew that systolic operation requires, and reports completion once the last vector has entered the bottom row.

---
 rtl/systolic_pkg.sv | 13 +
 rtl/skew_delay.sv | 43 ++++
 rtl/systolic_feeder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared constants and types for the systolic array front end.
package systolic_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN
  } feeder_state_t;

endpackage

// File: rtl/skew_delay.sv
// Data-plus-valid shift register of DEPTH stages. Data stages only advance
// behind a valid slot, so the tail holds the last valid word through bubbles.
module skew_delay
  import systolic_pkg::*;
#(
  parameter int unsigned DEPTH  = 1,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [DEPTH-1:0]  vld;
  logic [DATA_W-1:0] dat [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        dat[i] <= '0;
      end
    end else begin
      vld[0] <= in_valid;
      if (in_valid) begin
        dat[0] <= in_data;
      end
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) begin
          dat[i] <= dat[i-1];
        end
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Weight loader and skewed input streamer for the systolic PE array edge.
// Build option: FEEDER_ZERO_PAD_EN zeroes each input lane while its start is low.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned ROWS   = 2,
  parameter int unsigned COLS   = 2,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   w_valid,
  output logic                   w_ready,
  input  logic [COLS*DATA_W-1:0] w_data,
  input  logic                   x_valid,
  output logic                   x_ready,
  input  logic [ROWS*DATA_W-1:0] x_data,
  input  logic                   x_last,
  output logic [COLS*DATA_W-1:0] weight_out,
  output logic [ROWS-1:0]        load_weight,
  output logic [ROWS*DATA_W-1:0] input_out,
  output logic [ROWS-1:0]        start_out,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned     CW   = $clog2(ROWS) + 1;
  localparam logic [CW-1:0]   LAST = CW'(ROWS - 1);
  localparam logic [ROWS-1:0] ROW0 = ROWS'(1);

  feeder_state_t state, state_nxt;
  logic [CW-1:0] wrow, wrow_nxt;
  logic [CW-1:0] dcnt, dcnt_nxt;
  logic          wloaded, wloaded_nxt;
  logic          w_acc, x_acc;

  assign w_acc = w_valid & w_ready;
  assign x_acc = x_valid & x_ready;
  assign busy  = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    wrow_nxt    = wrow;
    dcnt_nxt    = dcnt;
    wloaded_nxt = wloaded;
    w_ready     = 1'b0;
    x_ready     = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        w_ready = 1'b1;
        // Weights win a tie, so x_ready is withheld while w_valid is up
        // to keep the input handshake honest.
        x_ready = wloaded & ~w_valid;
        if (w_valid) begin
          if (wrow == LAST) begin
            wloaded_nxt = 1'b1;
            wrow_nxt    = '0;
          end else begin
            wloaded_nxt = 1'b0;
            wrow_nxt    = wrow + CW'(1);
            state_nxt   = LOAD_W;
          end
        end else if (x_acc) begin
          if (x_last) begin
            dcnt_nxt  = LAST;
            state_nxt = DRAIN;
          end else begin
            state_nxt = STREAM;
          end
        end
      end
      LOAD_W: begin
        w_ready = 1'b1;
        if (w_valid) begin
          if (wrow == LAST) begin
            wloaded_nxt = 1'b1;
            wrow_nxt    = '0;
            state_nxt   = IDLE;
          end else begin
            wrow_nxt = wrow + CW'(1);
          end
        end
      end
      STREAM: begin
        x_ready = 1'b1;
        if (x_valid && x_last) begin
          dcnt_nxt  = LAST;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (dcnt == '0) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else begin
          dcnt_nxt = dcnt - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      wrow        <= '0;
      dcnt        <= '0;
      wloaded     <= 1'b0;
      weight_out  <= '0;
      load_weight <= '0;
    end else begin
      state       <= state_nxt;
      wrow        <= wrow_nxt;
      dcnt        <= dcnt_nxt;
      wloaded     <= wloaded_nxt;
      load_weight <= '0;
      if (w_acc) begin
        weight_out  <= w_data;
        load_weight <= ROW0 << wrow;
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic              lane_vld;
    logic [DATA_W-1:0] lane_dat;

    skew_delay #(
      .DEPTH (r + 1),
      .DATA_W(DATA_W)
    ) u_skew (
      .clk      (clk),
      .rst_n    (reset),
      .in_valid (x_acc),
      .in_data  (x_data[r*DATA_W +: DATA_W]),
      .out_valid(lane_vld),
      .out_data (lane_dat)
    );

    assign start_out[r] = lane_vld;
`ifdef FEEDER_ZERO_PAD_EN
    assign input_out[r*DATA_W +: DATA_W] = lane_vld ? lane_dat : '0;
`else
    assign input_out[r*DATA_W +: DATA_W] = lane_dat;
`endif
  end

endmodule
